// File: rtl/finite_mod_decoder.sv
// Finite-MOD offset decoder: iteratively reduces the input word modulo MOD and removes OFFSET.
// Optional FINITE_DEC_RANGE_CHECK_EN flags inputs >= MOD instead of reducing them.
module finite_mod_decoder #(
  parameter int MOD    = 20,
  parameter int OFFSET = 6,
  parameter int IN_W   = 7,
  parameter int OUT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam logic [IN_W-1:0] MOD_W = IN_W'(MOD);
  localparam logic [IN_W-1:0] OFF_W = IN_W'(OFFSET);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [IN_W-1:0]  r_acc;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef FINITE_DEC_RANGE_CHECK_EN
  logic r_out_err;
  assign out_err = r_out_err;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef FINITE_DEC_RANGE_CHECK_EN
      r_out_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
`ifdef FINITE_DEC_RANGE_CHECK_EN
            // Out-of-range residues skip reduction and report an error directly.
            if (in_data >= MOD_W) begin
              r_out_data  <= '0;
              r_out_err   <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_acc   <= in_data;
              r_state <= S_REDUCE;
            end
`else
            r_acc   <= in_data;
            r_state <= S_REDUCE;
`endif
          end
        end
        S_REDUCE: begin
          if (r_acc >= MOD_W) begin
            r_acc <= r_acc - MOD_W;
          end else begin
            // acc < OFFSET on the wrap path, so acc+MOD-OFFSET stays below MOD.
            if (r_acc >= OFF_W)
              r_out_data <= OUT_W'(r_acc - OFF_W);
            else
              r_out_data <= OUT_W'(r_acc + MOD_W - OFF_W);
`ifdef FINITE_DEC_RANGE_CHECK_EN
            r_out_err <= 1'b0;
`endif
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
